// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the program counter, reads instruction memory over a
// req/ack handshake and hands each fetched word to the instruction register with LoadIR.
module instruction_fetch_unit #(
   parameter int unsigned          ADDR_W   = 8,
   parameter int unsigned          INSTR_W  = 8,
   parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 fetch_start,
   input  logic                 pc_load,
   input  logic [ADDR_W-1:0]    pc_load_value,
   input  logic                 halt,
   output logic                 mem_req,
   output logic [ADDR_W-1:0]    mem_addr,
   input  logic [INSTR_W-1:0]   mem_rdata,
   input  logic                 mem_ack,
   output logic [INSTR_W-1:0]   instruction,
   output logic                 LoadIR,
   output logic [ADDR_W-1:0]    pc,
   output logic                 busy,
   output logic                 fetch_done,
   output logic                 halted
);

   typedef enum logic [1:0] {StIdle, StWait, StLoad, StHalted} state_e;

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
   logic                 mem_req_q, mem_req_d;
   logic [INSTR_W-1:0]   instruction_q, instruction_d;
   logic                 jump_pend_q, jump_pend_d;
   logic [ADDR_W-1:0]    jump_tgt_q, jump_tgt_d;
   logic                 halt_pend_q, halt_pend_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         pc_q          <= RESET_PC;
         mem_addr_q    <= RESET_PC;
         mem_req_q     <= 1'b0;
         instruction_q <= '0;
         jump_pend_q   <= 1'b0;
         jump_tgt_q    <= '0;
         halt_pend_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         mem_addr_q    <= mem_addr_d;
         mem_req_q     <= mem_req_d;
         instruction_q <= instruction_d;
         jump_pend_q   <= jump_pend_d;
         jump_tgt_q    <= jump_tgt_d;
         halt_pend_q   <= halt_pend_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      mem_addr_d    = mem_addr_q;
      mem_req_d     = mem_req_q;
      instruction_d = instruction_q;
      jump_pend_d   = jump_pend_q;
      jump_tgt_d    = jump_tgt_q;
      halt_pend_d   = halt_pend_q;

      unique case (state_q)
         StIdle: begin
            if (halt) begin
               state_d = StHalted;
            end else if (pc_load) begin
               pc_d = pc_load_value;
            end else if (fetch_start) begin
               mem_addr_d = pc_q;
               mem_req_d  = 1'b1;
               state_d    = StWait;
            end
         end
         StWait: begin
            if (pc_load) begin
               jump_pend_d = 1'b1;
               jump_tgt_d  = pc_load_value;
            end
            if (halt) begin
               halt_pend_d = 1'b1;
            end
            if (mem_ack) begin
               instruction_d = mem_rdata;
               mem_req_d     = 1'b0;
               pc_d          = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               state_d       = StLoad;
            end
         end
         StLoad: begin
            // A jump or halt arriving in this very cycle takes effect as if already pending.
            if (pc_load) begin
               pc_d = pc_load_value;
            end else if (jump_pend_q) begin
               pc_d = jump_tgt_q;
            end
            jump_pend_d = 1'b0;
            halt_pend_d = 1'b0;
            state_d     = (halt_pend_q || halt) ? StHalted : StIdle;
         end
         StHalted: begin
            state_d = StHalted;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign mem_req     = mem_req_q;
   assign mem_addr    = mem_addr_q;
   assign instruction = instruction_q;
   assign pc          = pc_q;
   assign LoadIR      = (state_q == StLoad);
   assign fetch_done  = (state_q == StLoad);
   assign busy        = (state_q == StWait) || (state_q == StLoad);
   assign halted      = (state_q == StHalted);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a small instruction-register model
// that captures the word on LoadIR.
module tb_instruction_fetch_unit;

   logic       clock = 1'b0;
   logic       reset;
   logic       fetch_start;
   logic       pc_load;
   logic [7:0] pc_load_value;
   logic       halt;
   logic       mem_req;
   logic [7:0] mem_addr;
   logic [7:0] mem_rdata;
   logic       mem_ack;
   logic [7:0] instruction;
   logic       LoadIR;
   logic [7:0] pc;
   logic       busy;
   logic       fetch_done;
   logic       halted;

   logic [7:0] ir_q;
   int         errs   = 0;
   int         checks = 0;
   int         pulses;

   instruction_fetch_unit #(
      .ADDR_W   (8),
      .INSTR_W  (8),
      .RESET_PC (8'h00)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .fetch_start   (fetch_start),
      .pc_load       (pc_load),
      .pc_load_value (pc_load_value),
      .halt          (halt),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_rdata     (mem_rdata),
      .mem_ack       (mem_ack),
      .instruction   (instruction),
      .LoadIR        (LoadIR),
      .pc            (pc),
      .busy          (busy),
      .fetch_done    (fetch_done),
      .halted        (halted)
   );

   always #5 clock = ~clock;

   // Instruction register: opcode = ir_q[7:4], data = ir_q[3:0].
   always @(posedge clock) begin
      if (LoadIR) ir_q <= instruction;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1; fetch_start = 1'b0; pc_load = 1'b0; pc_load_value = 8'h00;
      halt = 1'b0; mem_rdata = 8'h00; mem_ack = 1'b0;
      #12;
      chk("rst_pc", pc, 8'h00);
      chk("rst_addr", mem_addr, 8'h00);
      chk("rst_req", mem_req, 1'b0);
      chk("rst_instr", instruction, 8'h00);
      chk("rst_flags", {LoadIR, fetch_done, busy, halted}, 4'b0000);
      reset = 1'b0;
      step();

      // Zero-wait fetch of A5 from address 0
      fetch_start = 1'b1;
      step();
      fetch_start = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hA5;
      chk("f1_req", mem_req, 1'b1);
      chk("f1_addr", mem_addr, 8'h00);
      chk("f1_busy_noload", {busy, LoadIR}, 2'b10);
      step();
      mem_ack = 1'b0;
      chk("f1_load", {LoadIR, fetch_done, mem_req}, 3'b110);
      chk("f1_instr", instruction, 8'hA5);
      chk("f1_pc", pc, 8'h01);
      step();
      chk("f1_idle", {LoadIR, busy}, 2'b00);
      chk("f1_ir", ir_q, 8'hA5);

      // Ack delayed 5 cycles, then stray acks
      pulses = 0;
      fetch_start = 1'b1;
      step();
      fetch_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("f2_hold", {mem_req, mem_addr}, {1'b1, 8'h01});
         if (LoadIR) pulses++;
         step();
      end
      mem_ack = 1'b1; mem_rdata = 8'h5A;
      step();
      mem_rdata = 8'hEE;
      for (int i = 0; i < 3; i++) begin
         if (LoadIR) pulses++;
         step();
      end
      mem_ack = 1'b0;
      chk("f2_pulses", pulses, 1);
      chk("f2_instr", instruction, 8'h5A);
      chk("f2_pc", pc, 8'h02);
      chk("f2_req", mem_req, 1'b0);

      // pc_load beats fetch_start in IDLE
      pc_load = 1'b1; pc_load_value = 8'h40; fetch_start = 1'b1;
      step();
      pc_load = 1'b0; fetch_start = 1'b0;
      chk("jmp_pc", pc, 8'h40);
      chk("jmp_noreq", {mem_req, busy}, 2'b00);
      step();
      chk("jmp_noreq2", mem_req, 1'b0);

      // Wrap-around at FF, IR decode of 3C
      pc_load = 1'b1; pc_load_value = 8'hFF;
      step();
      pc_load = 1'b0; fetch_start = 1'b1;
      step();
      fetch_start = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h3C;
      chk("wrap_addr", mem_addr, 8'hFF);
      step();
      mem_ack = 1'b0;
      chk("wrap_pc", pc, 8'h00);
      chk("wrap_load", LoadIR, 1'b1);
      step();
      chk("ir_opcode", ir_q[7:4], 4'h3);
      chk("ir_data", ir_q[3:0], 4'hC);

      // Jump during WAIT at pc=3
      pc_load = 1'b1; pc_load_value = 8'h03;
      step();
      pc_load = 1'b0; fetch_start = 1'b1;
      step();
      fetch_start = 1'b0; pc_load = 1'b1; pc_load_value = 8'h10;
      chk("jw_addr", mem_addr, 8'h03);
      step();
      pc_load = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h77;
      chk("jw_still_wait", {busy, LoadIR, mem_addr}, {2'b10, 8'h03});
      step();
      mem_ack = 1'b0;
      chk("jw_load", {LoadIR, instruction}, {1'b1, 8'h77});
      step();
      chk("jw_pc", pc, 8'h10);

      // Halt during WAIT
      fetch_start = 1'b1;
      step();
      fetch_start = 1'b0; halt = 1'b1;
      step();
      halt = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h99;
      step();
      mem_ack = 1'b0;
      chk("h_load", {LoadIR, halted, instruction}, {2'b10, 8'h99});
      step();
      chk("h_halted", {halted, busy}, 2'b10);
      fetch_start = 1'b1; pc_load = 1'b1; pc_load_value = 8'h22;
      step();
      step();
      fetch_start = 1'b0; pc_load = 1'b0;
      chk("h_ignore", {halted, mem_req, pc}, {2'b10, 8'h11});
      chk("h_instr_kept", instruction, 8'h99);
      #2 reset = 1'b1;
      #1;
      chk("h_reset", {halted, pc}, {1'b0, 8'h00});
      #1 reset = 1'b0;
      step();

      // Reset mid-WAIT, late ack ignored
      fetch_start = 1'b1;
      step();
      fetch_start = 1'b0;
      chk("rw_req", mem_req, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("rw_req_drop", mem_req, 1'b0);
      chk("rw_instr", instruction, 8'h00);
      mem_ack = 1'b1; mem_rdata = 8'hEE;
      #1 reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (LoadIR) pulses++;
      end
      mem_ack = 1'b0;
      chk("rw_no_load", pulses, 0);
      chk("rw_late_ack", {mem_req, busy, instruction, pc}, {2'b00, 8'h00, 8'h00});

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
